// File: rtl/clk_gen_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_gen_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int DEFAULT_DIV_DEF = 500;

    // Width of a channel index; a single channel still needs a 1-bit port.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // A programmed half-period of 0 runs exactly like 1.
    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow half-period, divided clock and tick.
module clk_div_chan
    import clk_gen_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             restart,
    input  logic             we,
    input  logic [CNT_W-1:0] wdiv,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] eff;
    logic             term;

    always_comb begin
        eff  = CNT_W'(eff_div(32'(active)));
        term = (count == eff - CNT_W'(1));
    end

    // New divisors only land on a half-period boundary, on restart, or
    // while stopped, so clk_out never produces a runt phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            clk_out <= 1'b1;
            tick    <= 1'b0;
            active  <= DEF_DIV;
            shadow  <= DEF_DIV;
            pending <= 1'b0;
        end else if (restart) begin
            count   <= '0;
            clk_out <= 1'b1;
            tick    <= 1'b0;
            pending <= 1'b0;
            if (we) begin
                active <= wdiv;
                shadow <= wdiv;
            end else if (pending) begin
                active <= shadow;
            end
        end else if (en) begin
            if (term) begin
                count   <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
                pending <= 1'b0;
                if (we) begin
                    active <= wdiv;
                    shadow <= wdiv;
                end else if (pending) begin
                    active <= shadow;
                end
            end else begin
                count <= count + CNT_W'(1);
                tick  <= 1'b0;
                if (we) begin
                    shadow  <= wdiv;
                    pending <= 1'b1;
                end
            end
        end else begin
            tick <= 1'b0;
            if (pending) begin
                active  <= shadow;
                count   <= '0;
                pending <= 1'b0;
            end
            // A write while stopped becomes pending and lands next cycle.
            if (we) begin
                shadow  <= wdiv;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_gen_multi.sv
// NUM_CH independent programmable clock dividers sharing one config port.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CH_W       = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    // cfg_we is a single-cycle strobe with no backpressure: every write is
    // accepted in the cycle it is presented; writes to a channel index at or
    // above NUM_CH match no channel and are dropped.
    logic [NUM_CH-1:0] cfg_hit;

    always_comb begin
        cfg_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit[i] = cfg_we && (int'(cfg_ch) == i);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (ch_en[g]),
            .restart (sync_restart),
            .we      (cfg_hit[g]),
            .wdiv    (cfg_div),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pending (cfg_pending[g])
        );
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed bench for clk_gen_multi (2 channels, 8-bit counters, default div 4).
module tb_clk_gen_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ch_en;
    logic       sync_restart;
    logic       cfg_we;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [1:0] cfg_pending;
    logic [1:0] clk_out;
    logic [1:0] tick;

    // Second instance with a non-power-of-two channel count for out-of-range writes.
    logic [2:0] ch_en3;
    logic       cfg_we3;
    logic [1:0] cfg_ch3;
    logic [2:0] cfg_pending3;
    logic [2:0] clk_out3;
    logic [2:0] tick3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clk_gen_multi #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(4)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_pending  (cfg_pending),
        .clk_out      (clk_out),
        .tick         (tick)
    );

    clk_gen_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) u_dut3 (
        .clk          (clk),
        .reset        (reset),
        .ch_en        (ch_en3),
        .sync_restart (1'b0),
        .cfg_we       (cfg_we3),
        .cfg_ch       (cfg_ch3),
        .cfg_div      (cfg_div),
        .cfg_pending  (cfg_pending3),
        .clk_out      (clk_out3),
        .tick         (tick3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One active edge, then return at the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_cfg(input logic [0:0] ch, input logic [7:0] div);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_div = div;
        cyc();
        cfg_we  = 1'b0;
    endtask

    // Both channels start at count 0 with clk_out = s; h = half-period, 0 = held.
    task automatic run2(input string tag, input int h0, input int h1, input int n,
                        input logic s0, input logic s1);
        logic e0, e1, t0, t1;
        for (int j = 1; j <= n; j++) begin
            cyc();
            e0 = (h0 == 0) ? s0 : (s0 ^ logic'((j / h0) % 2));
            e1 = (h1 == 0) ? s1 : (s1 ^ logic'((j / h1) % 2));
            t0 = (h0 != 0) && (j % h0 == 0) && e0;
            t1 = (h1 != 0) && (j % h1 == 0) && e1;
            check($sformatf("%s_clk_%0d", tag, j), 32'(clk_out), 32'({e1, e0}));
            check($sformatf("%s_tick_%0d", tag, j), 32'(tick), 32'({t1, t0}));
            check($sformatf("%s_pend_%0d", tag, j), 32'(cfg_pending), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; ch_en = 2'b00; sync_restart = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        ch_en3 = 3'b000; cfg_we3 = 1'b0; cfg_ch3 = '0;
        @(negedge clk);
        cyc();
        cyc();
        reset = 1'b0;

        // 1: reset state, then default div 4 on channel 0 only
        check("rst_clk", 32'(clk_out), 32'h3);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_pend", 32'(cfg_pending), 32'h0);
        ch_en = 2'b01;
        run2("s1", 4, 0, 16, 1'b1, 1'b1);

        // 2: div 1 and div 0 while stopped, then run
        ch_en = 2'b00;
        write_cfg(1'b0, 8'd1);
        check("s2_pend_set", 32'(cfg_pending), 32'h1);
        cyc();
        check("s2_pend_clr", 32'(cfg_pending), 32'h0);
        ch_en = 2'b01;
        run2("s2a", 1, 0, 8, 1'b1, 1'b1);
        ch_en = 2'b00;
        write_cfg(1'b0, 8'd0);
        check("s2_pend0_set", 32'(cfg_pending), 32'h1);
        cyc();
        ch_en = 2'b01;
        run2("s2b", 1, 0, 8, 1'b1, 1'b1);

        // 3: change 4 -> 2 mid half-period, lands at the boundary
        ch_en = 2'b00;
        write_cfg(1'b0, 8'd4);
        cyc();
        ch_en = 2'b01;
        cyc();
        check("s3_e1_clk", 32'(clk_out), 32'h3);
        write_cfg(1'b0, 8'd2);
        check("s3_e2_pend", 32'(cfg_pending), 32'h1);
        cyc();
        check("s3_e3_pend", 32'(cfg_pending), 32'h1);
        check("s3_e3_clk", 32'(clk_out), 32'h3);
        cyc();
        check("s3_e4_pend", 32'(cfg_pending), 32'h0);
        check("s3_e4_clk", 32'(clk_out), 32'h2);
        run2("s3", 2, 0, 4, 1'b0, 1'b1);

        // 4: write in the terminal-count cycle bypasses the shadow
        cyc();
        check("s4_pre_clk", 32'(clk_out), 32'h2);
        write_cfg(1'b0, 8'd6);
        check("s4_byp_clk", 32'(clk_out), 32'h3);
        check("s4_byp_tick", 32'(tick), 32'h1);
        check("s4_byp_pend", 32'(cfg_pending), 32'h0);
        run2("s4", 6, 0, 12, 1'b1, 1'b1);

        // 4b: out-of-range channel on a 3-channel instance is ignored
        cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_div = 8'd1;
        cyc();
        cfg_we3 = 1'b0;
        check("s4_bad_pend", 32'(cfg_pending3), 32'h0);
        cyc();
        check("s4_bad_pend2", 32'(cfg_pending3), 32'h0);
        check("s4_bad_clk", 32'(clk_out3), 32'h7);
        cfg_we3 = 1'b1; cfg_ch3 = 2'd2;
        cyc();
        cfg_we3 = 1'b0;
        check("s4_ok_pend", 32'(cfg_pending3), 32'h4);

        // 5: div 4 and 3 with arbitrary phases, then phase-align
        write_cfg(1'b0, 8'd4);
        write_cfg(1'b1, 8'd3);
        ch_en = 2'b11;
        for (int k = 0; k < 5; k++) cyc();
        sync_restart = 1'b1;
        cyc();
        sync_restart = 1'b0;
        check("s5_rs_clk", 32'(clk_out), 32'h3);
        check("s5_rs_tick", 32'(tick), 32'h0);
        check("s5_rs_pend", 32'(cfg_pending), 32'h0);
        run2("s5", 4, 3, 24, 1'b1, 1'b1);

        // 6: reset mid half-period with div 7 pending
        write_cfg(1'b0, 8'd7);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("s6_rst_clk", 32'(clk_out), 32'h3);
        check("s6_rst_tick", 32'(tick), 32'h0);
        check("s6_rst_pend", 32'(cfg_pending), 32'h0);
        ch_en = 2'b01;
        run2("s6", 4, 0, 16, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
